alu_seq: RTL

Parametrised, handshaked, multi-cycle successor to the single-cycle execute ALU. It sits in the execute stage and adds to the existing seven basic operations the OR, signed/unsigned compare, multiply and divide/remainder operations, all generalised to XLEN bits. Basic operations complete in one cycle; multiply and divide run an iterative radix-2 datapath. All results are registered behind a valid/ready handshake so the pipeline can stall on either side.

---
 rtl/alu_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle basic ops plus iterative radix-2
// multiply (shift-add) and restoring divide, all results registered.
module alu_seq #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SRA  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;    // multiplicand magnitude or divisor magnitude
  logic [PW-1:0]   acc;      // product {hi,lo} or {remainder,quotient}
  logic            neg;      // product / quotient must be negated
  logic            rneg;     // remainder must be negated
  logic            div0;
  logic            hi_sel;   // mulh: take upper half
  logic            rem_sel;  // rem/remu: take remainder

  logic            accept;
  logic            is_mul_in;
  logic            is_div_in;
  logic            is_sgn_in;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] basic;

  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_nxt;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_sub;
  logic            div_ge;
  logic [PW-1:0]   div_nxt;
  logic [PW-1:0]   prod_s;
  logic [XLEN-1:0] mul_fin;
  logic [XLEN-1:0] quo_fin;
  logic [XLEN-1:0] rem_fin;
  logic [XLEN-1:0] fin;

  // Operand decode at the input, used only on the accepting edge
  assign is_mul_in = (op[3:1] == 3'b101);
  assign is_div_in = (op[3:2] == 2'b11);
  assign is_sgn_in = is_mul_in || (is_div_in && !op[0]);
  assign sa        = is_sgn_in && a[XLEN-1];
  assign sb        = is_sgn_in && b[XLEN-1];
  assign mag_a     = sa ? -a : a;
  assign mag_b     = sb ? -b : b;
  assign accept    = in_valid && in_ready;

  // Single-cycle operations
  always_comb begin
    basic = '0;
    case (op)
      OP_ADD:  basic = a + b;
      OP_SUB:  basic = a - b;
      OP_SRA:  basic = XLEN'($signed(a) >>> b[SHW-1:0]);
      OP_SLL:  basic = a << b[SHW-1:0];
      OP_SRL:  basic = a >> b[SHW-1:0];
      OP_AND:  basic = a & b;
      OP_XOR:  basic = a ^ b;
      OP_OR:   basic = a | b;
      OP_SLT:  basic = XLEN'($signed(a) < $signed(b));
      OP_SLTU: basic = XLEN'(a < b);
      default: basic = '0;
    endcase
  end

  // One shift-add step: conditionally add into the high half, then shift right
  assign mul_sum = {1'b0, acc[PW-1:XLEN]} + {1'b0, (acc[0] ? mcand : '0)};
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // One restoring-divide step: shift next dividend bit into the remainder
  assign div_sh  = {acc[PW-1:XLEN], acc[XLEN-1]};
  assign div_ge  = (div_sh >= {1'b0, mcand});
  assign div_sub = div_sh - {1'b0, mcand};
  assign div_nxt = {(div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0]),
                    acc[XLEN-2:0], div_ge};

  // Sign fix-up of the finished magnitudes
  assign prod_s  = neg ? -acc : acc;
  assign mul_fin = hi_sel ? prod_s[PW-1:XLEN] : prod_s[XLEN-1:0];
  assign quo_fin = div0 ? '1 : (neg ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
  assign rem_fin = rneg ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];
  assign fin     = (state == S_MUL) ? mul_fin : (rem_sel ? rem_fin : quo_fin);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state_nxt = is_mul_in ? S_MUL : (is_div_in ? S_DIV : S_DONE);
        end
        S_DONE: begin
          if (accept)         state_nxt = is_mul_in ? S_MUL : (is_div_in ? S_DIV : S_DONE);
          else if (out_ready) state_nxt = S_IDLE;
        end
        S_MUL, S_DIV: begin
          if (cnt == '0) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Combinational handshake output; flush blocks acceptance in its own cycle
  always_comb begin
    in_ready = 1'b0;
    if (!flush) in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      rneg      <= 1'b0;
      div0      <= 1'b0;
      hi_sel    <= 1'b0;
      rem_sel   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if ((state == S_DONE) && out_ready) out_valid <= 1'b0;
      if (accept) begin
        cnt     <= CW'(XLEN);
        neg     <= sa ^ sb;
        rneg    <= sa;
        div0    <= (b == '0);
        hi_sel  <= op[0];
        rem_sel <= op[1];
        if (is_mul_in) begin
          acc   <= {{XLEN{1'b0}}, mag_b};
          mcand <= mag_a;
        end else if (is_div_in) begin
          acc   <= {{XLEN{1'b0}}, mag_a};
          mcand <= mag_b;
        end else begin
          result    <= basic;
          zero      <= (basic == '0);
          out_valid <= 1'b1;
        end
      end else if ((state == S_MUL) || (state == S_DIV)) begin
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
          acc <= (state == S_MUL) ? mul_nxt : div_nxt;
        end else begin
          result    <= fin;
          zero      <= (fin == '0);
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
